// File: rtl/requantize_pc_stream_pkg.sv
// requant_pkg: shared widths, table entry type and the round/clamp helpers
// used by every lane of requantize_pc_stream.
package requant_pkg;
  localparam int ACC_BITS  = 32;
  localparam int OUT_BITS  = 8;
  localparam int MULT_BITS = 16;
  localparam int SHIFT_MAX = 47;
  localparam int SUM_W     = ACC_BITS + 1;
  localparam int PROD_W    = ACC_BITS + MULT_BITS + 1;
  localparam int V_W       = PROD_W + 1;
  localparam logic signed [V_W-1:0] OUT_MIN = V_W'(-(2 ** (OUT_BITS - 1)));
  localparam logic signed [V_W-1:0] OUT_MAX = V_W'(2 ** (OUT_BITS - 1) - 1);
  typedef struct packed {
    logic signed [MULT_BITS-1:0] mult;
    logic [5:0]                  shift;
  } entry_t;
  typedef struct packed {
    logic signed [OUT_BITS-1:0] q;
    logic                       sat;
  } clamp_t;
  // Round half toward +inf; shifts beyond SHIFT_MAX are clamped to it.
  function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [PROD_W-1:0] prod, input logic [5:0] s);
    logic [5:0] se;
    logic signed [PROD_W-1:0] half;
    se = (s > 6'(SHIFT_MAX)) ? 6'(SHIFT_MAX) : s;
    half = (se == 6'd0) ? '0 : PROD_W'(1) << (se - 6'd1);
    return (prod + half) >>> se;
  endfunction
  // Saturation is judged against the full output range, so a ReLU clamp is not counted.
  function automatic clamp_t sat_clamp(input logic signed [V_W-1:0] v, lo, hi);
    clamp_t c;
    c.q = (v > hi) ? OUT_BITS'(hi) : (v < lo) ? OUT_BITS'(lo) : OUT_BITS'(v);
    c.sat = (v > hi) || (v < OUT_MIN);
    return c;
  endfunction
endpackage

// File: rtl/requantize_pc_stream_if.sv
// requantize_pc_stream_if: accumulator input stream and requantized output stream.
interface requantize_pc_stream_if #(parameter int LANES = 16, parameter int GRP_W = 6);
  import requant_pkg::*;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*ACC_BITS-1:0] in_acc;
  logic [LANES*ACC_BITS-1:0] in_bias;
  logic [GRP_W-1:0]          in_grp;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*OUT_BITS-1:0] out_q;
  logic                      out_last;
  modport master (output in_valid, in_acc, in_bias, in_grp, in_last, out_ready,
                  input  in_ready, out_valid, out_q, out_last);
  modport slave  (input  in_valid, in_acc, in_bias, in_grp, in_last, out_ready,
                  output in_ready, out_valid, out_q, out_last);
endinterface

// File: rtl/requantize_pc_stream_lane.sv
// requant_lane: one lane of the 3-stage datapath (bias add, multiply, round/offset/clamp).
module requant_lane
  import requant_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       adv_i,
  input  entry_t                     ent_i,
  input  logic signed [ACC_BITS-1:0] acc_i,
  input  logic signed [ACC_BITS-1:0] bias_i,
  input  logic signed [OUT_BITS-1:0] zp_i,
  input  logic                       relu_i,
  output logic signed [OUT_BITS-1:0] q_o,
  output logic                       sat_o
);
  logic signed [SUM_W-1:0]  sum_q;
  entry_t                   ent_q;
  logic signed [PROD_W-1:0] prod_q;
  logic [5:0]               shift_q;
  logic signed [V_W-1:0]    zp, v, lo;
  clamp_t                   c;
  always_comb begin
    zp = V_W'(zp_i);
    v = V_W'(round_shift(prod_q, shift_q)) + zp;
    lo = relu_i ? zp : OUT_MIN;
    c = sat_clamp(v, lo, OUT_MAX);
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      sum_q <= '0;
      ent_q <= '0;
      prod_q <= '0;
      shift_q <= '0;
      q_o <= '0;
      sat_o <= 1'b0;
    end else if (adv_i) begin
      sum_q <= SUM_W'(acc_i) + SUM_W'(bias_i);
      ent_q <= ent_i;
      prod_q <= PROD_W'(sum_q) * PROD_W'($signed(ent_q.mult));
      shift_q <= ent_q.shift;
      q_o <= c.q;
      sat_o <= c.sat;
    end
endmodule

// File: rtl/requantize_pc_stream.sv
// requantize_pc_stream: per-channel requantizer with valid/ready backpressure,
// writable {mult, shift} table per group and lane, and a saturation counter.
module requantize_pc_stream
  import requant_pkg::*;
#(
  parameter  int LANES     = 16,
  parameter  int CH_GROUPS = 64,
  localparam int GRP_W     = $clog2(CH_GROUPS),
  localparam int LANE_W    = $clog2(LANES),
  localparam int CNT_W     = $clog2(LANES + 1)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        cfg_wr_en,
  input  logic [GRP_W-1:0]            cfg_wr_grp,
  input  logic [LANE_W-1:0]           cfg_wr_lane,
  input  logic signed [MULT_BITS-1:0] cfg_wr_mult,
  input  logic [5:0]                  cfg_wr_shift,
  input  logic signed [7:0]           cfg_zp_out,
  input  logic                        cfg_symmetric,
  input  logic                        cfg_relu,
  input  logic                        cfg_clr_stats,
  requantize_pc_stream_if.slave       bus,
  output logic [31:0]                 sat_cnt
);
  entry_t                     tbl_q [CH_GROUPS][LANES];
  logic                       adv, grp_ok;
  logic [2:0]                 v_q, l_q;
  logic [LANES-1:0]           sat;
  logic [CNT_W-1:0]           n_sat;
  logic [32:0]                cnt_sum;
  logic signed [OUT_BITS-1:0] zp;
  assign adv = !v_q[2] || bus.out_ready;
  assign bus.in_ready = adv && RESET;
  assign bus.out_valid = v_q[2];
  assign bus.out_last = l_q[2];
  assign grp_ok = 32'(bus.in_grp) < CH_GROUPS;
  assign zp = cfg_symmetric ? '0 : cfg_zp_out;
  // Table is read combinationally at accept, so a same-cycle write is seen only by later beats.
  always_ff @(posedge CLK)
    if (cfg_wr_en && 32'(cfg_wr_grp) < CH_GROUPS)
      tbl_q[cfg_wr_grp][cfg_wr_lane] <= '{mult: cfg_wr_mult, shift: cfg_wr_shift};
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      v_q <= '0;
      l_q <= '0;
    end else if (adv) begin
      v_q <= {v_q[1:0], bus.in_valid};
      l_q <= {l_q[1:0], bus.in_last};
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .CLK    (CLK),
      .RESET  (RESET),
      .adv_i  (adv),
      .ent_i  (grp_ok ? tbl_q[bus.in_grp][i] : '0),
      .acc_i  (bus.in_acc[i*ACC_BITS +: ACC_BITS]),
      .bias_i (bus.in_bias[i*ACC_BITS +: ACC_BITS]),
      .zp_i   (zp),
      .relu_i (cfg_relu),
      .q_o    (bus.out_q[i*OUT_BITS +: OUT_BITS]),
      .sat_o  (sat[i])
    );
  end
  always_comb begin
    n_sat = '0;
    for (int k = 0; k < LANES; k++) n_sat = n_sat + CNT_W'(sat[k]);
    cnt_sum = {1'b0, sat_cnt} + 33'(n_sat);
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) sat_cnt <= '0;
    else if (cfg_clr_stats) sat_cnt <= '0;
    else if (bus.out_valid && bus.out_ready) sat_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
endmodule

// File: tb/tb_requantize_pc_stream.sv
// tb_requantize_pc_stream: directed vectors with hand-computed expectations.
module tb_requantize_pc_stream;
  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic [5:0]        cfg_wr_grp = '0;
  logic [3:0]        cfg_wr_lane = '0;
  logic signed [15:0] cfg_wr_mult = '0;
  logic [5:0]        cfg_wr_shift = '0;
  logic signed [7:0] cfg_zp_out = '0;
  logic              cfg_symmetric = 1'b1;
  logic              cfg_relu = 1'b0;
  logic              cfg_clr_stats = 1'b0;
  logic [31:0]       sat_cnt;
  int                n_chk = 0, n_err = 0;
  int                bi, nr;
  int                rv [8];
  logic              rl [8];
  logic [7:0]        held;
  logic              seen;

  requantize_pc_stream_if #(.LANES(16), .GRP_W(6)) bus ();

  requantize_pc_stream #(.LANES(16), .CH_GROUPS(64)) dut (
    .CLK(CLK), .RESET(RESET), .cfg_wr_en(cfg_wr_en), .cfg_wr_grp(cfg_wr_grp),
    .cfg_wr_lane(cfg_wr_lane), .cfg_wr_mult(cfg_wr_mult), .cfg_wr_shift(cfg_wr_shift),
    .cfg_zp_out(cfg_zp_out), .cfg_symmetric(cfg_symmetric), .cfg_relu(cfg_relu),
    .cfg_clr_stats(cfg_clr_stats), .bus(bus), .sat_cnt(sat_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic signed [7:0] q(input int l);
    return bus.out_q[8*l +: 8];
  endfunction

  task automatic wr(input int g, input int l, input int m, input int sh);
    cfg_wr_en = 1'b1;
    cfg_wr_grp = 6'(g);
    cfg_wr_lane = 4'(l);
    cfg_wr_mult = 16'(m);
    cfg_wr_shift = 6'(sh);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic wr_all(input int g, input int m, input int sh);
    for (int l = 0; l < 16; l++) wr(g, l, m, sh);
  endtask

  task automatic drive(input int a, input int b, input int g, input int last);
    bus.in_valid = 1'b1;
    bus.in_acc = '0;
    bus.in_bias = '0;
    bus.in_acc[31:0] = 32'(a);
    bus.in_bias[31:0] = 32'(b);
    bus.in_grp = 6'(g);
    bus.in_last = last[0];
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic expect_next(input string tag, input int e);
    wait_valid(tag);
    check(tag, q(0), e);
    tick();
  endtask

  task automatic beat(input string tag, input int a, input int b, input int e);
    drive(a, b, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    expect_next(tag, e);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_acc = '0;
    bus.in_bias = '0;
    bus.in_grp = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_in_ready", 64'(bus.in_ready), 0);
    check("rst_sat_cnt", 64'(sat_cnt), 0);
    check("rst_out_q", q(0), 0);
    tick();
    tick();
    RESET = 1'b1;
    tick();
    check("idle_in_ready", 64'(bus.in_ready), 1);
    wr_all(0, 16384, 14);
    wr_all(1, 16384, 14);
    // identity scaling, lane 0 only carries data
    beat("id_127", 100, 27, 127);
    check("id_sat0", 64'(sat_cnt), 0);
    beat("id_200", 200, 0, 127);
    check("id_sat1", 64'(sat_cnt), 1);
    beat("id_m300", -300, 0, -128);
    check("id_sat2", 64'(sat_cnt), 2);
    // rounding
    wr(0, 0, 1, 1);
    beat("rnd_3", 3, 0, 2);
    beat("rnd_m3", -3, 0, -1);
    beat("rnd_5", 5, 0, 3);
    beat("rnd_m1", -1, 0, 0);
    wr(0, 0, 1, 0);
    beat("rnd_s0", -7, 0, -7);
    wr(0, 0, -16384, 60);
    beat("rnd_s60", int'(32'h80000000), int'(32'h80000000), 1);
    // relu and zero point
    wr(0, 0, 1, 0);
    cfg_symmetric = 1'b0;
    cfg_relu = 1'b1;
    cfg_zp_out = -8'sd5;
    beat("relu_zp", -15, 0, -5);
    cfg_symmetric = 1'b1;
    beat("relu_sym", -15, 0, 0);
    cfg_relu = 1'b0;
    cfg_symmetric = 1'b0;
    cfg_zp_out = 8'sd10;
    beat("zp_add", 50, 0, 60);
    check("relu_nosat", 64'(sat_cnt), 2);
    cfg_symmetric = 1'b1;
    cfg_zp_out = '0;
    // per-channel groups interleaved
    wr(1, 0, 2, 0);
    drive(10, 0, 0, 0);
    tick();
    drive(10, 0, 1, 0);
    tick();
    drive(10, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    expect_next("pc_g0a", 10);
    expect_next("pc_g1", 20);
    expect_next("pc_g0b", 10);
    // each lane its own entry
    for (int l = 0; l < 16; l++) wr(2, l, l + 1, 0);
    bus.in_acc = {16{32'd3}};
    bus.in_bias = '0;
    bus.in_grp = 6'd2;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid("pl");
    check("pl_l0", q(0), 3);
    check("pl_l5", q(5), 18);
    check("pl_l15", q(15), 48);
    tick();
    // write collides with accept of the same entry
    drive(10, 0, 0, 0);
    cfg_wr_en = 1'b1;
    cfg_wr_grp = '0;
    cfg_wr_lane = '0;
    cfg_wr_mult = 16'sd3;
    cfg_wr_shift = '0;
    tick();
    cfg_wr_en = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    expect_next("col_old", 10);
    expect_next("col_new", 30);
    // clear beats a same-cycle handshake
    wr(0, 0, 1, 0);
    drive(1000, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    wait_valid("clr");
    cfg_clr_stats = 1'b1;
    tick();
    cfg_clr_stats = 1'b0;
    check("clr_wins", 64'(sat_cnt), 0);
    beat("clr_after", 1000, 0, 127);
    check("cnt_after_clr", 64'(sat_cnt), 1);
    // backpressure: 8 beats, downstream stalls on cycles 4..6
    bi = 0;
    nr = 0;
    held = '0;
    for (int c = 0; c < 40 && nr < 8; c++) begin
      drive(bi + 1, 0, 0, int'(bi == 7));
      bus.in_valid = bi < 8;
      bus.out_ready = !(c >= 4 && c <= 6);
      #1;
      if (!bus.out_ready && bus.out_valid) begin
        check("bp_in_ready", 64'(bus.in_ready), 0);
        if (c > 4) check("bp_hold", q(0), $signed(held));
      end
      held = q(0);
      if (bus.out_valid && bus.out_ready) begin
        rv[nr] = int'(q(0));
        rl[nr] = bus.out_last;
        nr++;
      end
      if (bus.in_valid && bus.in_ready) bi++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_count", 64'(nr), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_val%0d", i), 64'(rv[i]), 64'(i + 1));
      check($sformatf("bp_last%0d", i), 64'(rl[i]), 64'(i == 7));
    end
    tick();
    tick();
    check("bp_drained", 64'(bus.out_valid), 0);
    // reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      drive(5, 0, 0, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid_inflight", 64'(bus.out_valid), 1);
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 0);
    check("mid_rst_ready", 64'(bus.in_ready), 0);
    check("mid_rst_q", q(0), 0);
    check("mid_rst_sat", 64'(sat_cnt), 0);
    tick();
    tick();
    RESET = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("post_rst_quiet", 64'(seen), 0);
    check("post_rst_sat", 64'(sat_cnt), 0);
    check("post_rst_ready", 64'(bus.in_ready), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
